// File: rtl/mpa_pkg.sv
// Shared constants, limb-count helper and FSM state type for the serial
// multi-precision adder/subtractor.
package mpa_pkg;

  localparam int OPW  = 514;
  localparam int RESW = 515;

  // ceil((opw+1)/limb): the result needs one bit beyond the operand width
  function automatic int nlimb(input int opw, input int limb);
    return (opw + limb) / limb;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mpaddsub_serial_addc_limb.sv
// Combinational W-bit adder slice with carry in and carry out.
module addc_limb #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/mpaddsub_serial.sv
// Serial multi-precision adder/subtractor: one LIMB-wide slice per clock,
// done pulses NLIMB cycles after the start-sampling edge.
module mpaddsub_serial #(
  parameter int OPW  = mpa_pkg::OPW,
  parameter int LIMB = 64
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic           subtract,
  input  logic [OPW-1:0] in_a,
  input  logic [OPW-1:0] in_b,
  output logic [OPW:0]   result,
  output logic           done,
  output logic           busy
);

  import mpa_pkg::*;

  localparam int NLIMB = nlimb(OPW, LIMB);
  localparam int EXTW  = NLIMB * LIMB;
  localparam int CNTW  = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(NLIMB - 1);

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [EXTW-1:0] a_q, a_d;
  logic [EXTW-1:0] b_q, b_d;
  logic [EXTW-1:0] res_q, res_d;
  logic            carry_q, carry_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic [LIMB-1:0] sum_s;
  logic            cout_s;

  // Operands shift right one limb per cycle, so the adder always sees bit 0.
  addc_limb #(.W(LIMB)) u_addc (
    .a    (a_q[LIMB-1:0]),
    .b    (b_q[LIMB-1:0]),
    .cin  (carry_q),
    .s    (sum_s),
    .cout (cout_s)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = EXTW'(in_a);
          b_d     = subtract ? ~(EXTW'(in_b)) : EXTW'(in_b);
          carry_d = subtract;
          cnt_d   = {CNTW{1'b0}};
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> LIMB;
        b_d     = b_q >> LIMB;
        // Sum limbs enter at the top; after NLIMB shifts limb 0 sits at bit 0.
        res_d   = {sum_s, res_q[EXTW-1:LIMB]};
        carry_d = cout_s;
        if (cnt_q == LAST) begin
          cnt_d   = {CNTW{1'b0}};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + CNTW'(1'b1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= {CNTW{1'b0}};
      a_q     <= {EXTW{1'b0}};
      b_q     <= {EXTW{1'b0}};
      res_q   <= {EXTW{1'b0}};
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign result = res_q[OPW:0];
  assign done   = done_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_mpaddsub_serial.sv
// Directed bench for mpaddsub_serial at LIMB=64 and LIMB=128 side by side.
module tb_mpaddsub_serial;

  logic         clk;
  logic         resetn;
  logic         start;
  logic         subtract;
  logic [513:0] in_a;
  logic [513:0] in_b;
  logic [514:0] result64, result128;
  logic         done64, done128;
  logic         busy64, busy128;

  int checks;
  int errors;

  typedef struct {
    string        name;
    logic         sub;
    logic [513:0] a;
    logic [513:0] b;
    logic [514:0] exp;
  } vec_t;

  vec_t vecs[9];

  mpaddsub_serial #(.OPW(514), .LIMB(64)) u_dut64 (
    .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
    .in_a(in_a), .in_b(in_b), .result(result64), .done(done64), .busy(busy64)
  );

  mpaddsub_serial #(.OPW(514), .LIMB(128)) u_dut128 (
    .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
    .in_a(in_a), .in_b(in_b), .result(result128), .done(done128), .busy(busy128)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [514:0] act, input logic [514:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one operation from a sample point (#1 after posedge) and follow both DUTs.
  task automatic do_op(input string nm, input logic s, input logic [513:0] a,
                       input logic [513:0] b, input logic [514:0] exp);
    int n64, n128;
    logic [514:0] r64, r128;
    logic busy_ok, pulse_ok;
    n64 = -1; n128 = -1; r64 = '0; r128 = '0; busy_ok = 1'b1; pulse_ok = 1'b1;
    subtract = s; in_a = a; in_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; subtract = ~s; in_a = ~a; in_b = ~b;
    for (int n = 0; n <= 12; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (done64)  begin if (n64  < 0) begin n64  = n; r64  = result64;  end else pulse_ok = 1'b0; end
      if (done128) begin if (n128 < 0) begin n128 = n; r128 = result128; end else pulse_ok = 1'b0; end
      if (busy64  !== (n < 9)) busy_ok = 1'b0;
      if (busy128 !== (n < 5)) busy_ok = 1'b0;
    end
    chk({nm, " lat64"},  515'(n64),  515'(9));
    chk({nm, " lat128"}, 515'(n128), 515'(5));
    chk({nm, " res64"},  r64,  exp);
    chk({nm, " res128"}, r128, exp);
    chk({nm, " busy"},   515'(busy_ok),  515'(1));
    chk({nm, " pulse"},  515'(pulse_ok), 515'(1));
  endtask

  initial begin
    logic [513:0] ones;
    logic [514:0] one515;
    int cnt64, cnt128, m, nd;
    logic [514:0] r;
    checks = 0; errors = 0;
    ones = '1;
    one515 = 515'd1;

    vecs[0] = '{"add_zero",    1'b0, 514'd0, 514'd0, 515'd0};
    vecs[1] = '{"sub_ones",    1'b1, ones,   ones,   515'd0};
    vecs[2] = '{"add_ones",    1'b0, ones,   ones,   {ones, 1'b0}};
    vecs[3] = '{"add_c64",     1'b0, 514'((one515 << 64) - 515'd1), 514'd1, one515 << 64};
    vecs[4] = '{"add_c128",    1'b0, 514'((one515 << 128) - 515'd1), 514'd1, one515 << 128};
    vecs[5] = '{"sub_0m1",     1'b1, 514'd0, 514'd1, {515{1'b1}}};
    vecs[6] = '{"sub_5m3",     1'b1, 514'd5, 514'd3, 515'd2};
    vecs[7] = '{"sub_3m5",     1'b1, 514'd3, 514'd5, {{514{1'b1}}, 1'b0}};
    vecs[8] = '{"add_top",     1'b0, one515[513:0] << 513, one515[513:0] << 513, one515 << 514};

    start = 1'b0; subtract = 1'b0; in_a = '0; in_b = '0;
    resetn = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst result64",  result64,  515'd0);
    chk("rst result128", result128, 515'd0);
    chk("rst done_busy", {513'd0, done64 | done128, busy64 | busy128}, 515'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      do_op(vecs[i].name, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Start while busy is ignored.
    cnt64 = 0; cnt128 = 0; r = '0;
    subtract = 1'b0; in_a = 514'h10; in_b = 514'h20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n <= 20; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (n == 3) begin start = 1'b1; in_a = 514'd7; in_b = 514'd7; end
      if (n == 4) start = 1'b0;
      if (done64) begin cnt64++; if (n == 9) r = result64; end
      if (done128) cnt128++;
    end
    chk("busy_start res",   r, 515'h30);
    chk("busy_start cnt64", 515'(cnt64), 515'd1);
    chk("busy_start cnt128", 515'(cnt128), 515'd1);

    // Back-to-back: start held in the done cycle.
    subtract = 1'b0; in_a = 514'd5; in_b = 514'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = -1; r = '0;
    for (int n = 0; n <= 15; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (nd < 0 && done64) begin
        nd = n; r = result64;
        subtract = 1'b1; in_a = 514'd5; in_b = 514'd3; start = 1'b1;
        break;
      end
    end
    chk("b2b first lat", 515'(nd), 515'd9);
    chk("b2b first res", r, 515'd8);
    @(posedge clk); #1;
    start = 1'b0;
    m = -1; r = '0;
    for (int n = 0; n <= 15; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (m < 0 && done64) begin m = n; r = result64; end
    end
    chk("b2b second lat", 515'(m), 515'd9);
    chk("b2b second res", r, 515'd2);

    // Reset in the middle of RUN aborts without a done.
    subtract = 1'b0; in_a = 514'd5; in_b = 514'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 4; n++) begin @(posedge clk); #1; end
    resetn = 1'b0;
    #1;
    chk("abort result64",  result64,  515'd0);
    chk("abort result128", result128, 515'd0);
    chk("abort done_busy", {513'd0, done64 | done128, busy64 | busy128}, 515'd0);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    cnt64 = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (done64 || done128) cnt64++;
    end
    chk("abort no done", 515'(cnt64), 515'd0);
    do_op("post_reset", 1'b0, 514'd100, 514'd23, 515'd123);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
